// File: rtl/tp84_audio_pkg.sv
// Shared sample type, full-scale limits and saturation helper for the audio decimator.
// Build option TP84_AUDIO_DCBLOCK_EN selects the DC-blocking filter in tp84_dc_blocker.
package tp84_audio_pkg;

  typedef logic signed [15:0] sample_t;

  localparam int SAMPLE_MAX = 32767;
  localparam int SAMPLE_MIN = -32768;
  // Filter arithmetic width: wide enough for a full-swing step plus y_prev.
  localparam int FILT_W     = 18;

  function automatic sample_t sat_sample(input logic signed [FILT_W-1:0] v);
    sample_t r;
    if (v > FILT_W'(SAMPLE_MAX)) begin
      r = sample_t'(SAMPLE_MAX);
    end else if (v < FILT_W'(SAMPLE_MIN)) begin
      r = sample_t'(SAMPLE_MIN);
    end else begin
      r = v[15:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/tp84_audio_decimator_if.sv
// Audio stream bundle between the game mixer/pause logic and the decimator.
// Build option TP84_AUDIO_DCBLOCK_EN does not change this interface.
interface tp84_audio_decimator_if;
  import tp84_audio_pkg::*;

  sample_t sound_in;
  logic    mute;
  sample_t audio_out;
  logic    audio_valid;

  modport master (output sound_in, output mute, input audio_out, input audio_valid);
  modport slave  (input sound_in, input mute, output audio_out, output audio_valid);

endinterface

// File: rtl/tp84_dc_blocker.sv
// Output stage: one-pole DC blocker when TP84_AUDIO_DCBLOCK_EN is defined, plain register otherwise.
// Updates only on ce; mute zeroes the output while the filter state keeps running.
module tp84_dc_blocker
  import tp84_audio_pkg::*;
#(
  parameter int DC_SHIFT = 8
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    ce,
  input  logic    mute,
  input  sample_t x,
  output sample_t y
);

`ifdef TP84_AUDIO_DCBLOCK_EN
  sample_t                  x_prev;
  sample_t                  y_prev;
  logic signed [FILT_W-1:0] y_full;
  sample_t                  y_sat;

  // y = x - x_prev + y_prev - y_prev*2^-k, leak term floored by the arithmetic shift
  always_comb begin
    y_full = FILT_W'(x) - FILT_W'(x_prev) + FILT_W'(y_prev) - FILT_W'(y_prev >>> DC_SHIFT);
    y_sat  = sat_sample(y_full);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_prev <= '0;
      y_prev <= '0;
      y      <= '0;
    end else if (ce) begin
      x_prev <= x;
      y_prev <= y_sat;
      y      <= mute ? sample_t'(0) : y_sat;
    end
  end
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y <= '0;
    end else if (ce) begin
      y <= mute ? sample_t'(0) : x;
    end
  end
`endif

endmodule

// File: rtl/tp84_audio_decimator.sv
// Boxcar decimator by 2^DECIM_LOG2 followed by the tp84_dc_blocker output stage.
// Define TP84_AUDIO_DCBLOCK_EN to enable the DC-blocking filter; timing is identical either way.
module tp84_audio_decimator
  import tp84_audio_pkg::*;
#(
  parameter int DECIM_LOG2 = 10,
  parameter int DC_SHIFT   = 8
) (
  input  logic                   clk_49m,
  input  logic                   reset,
  tp84_audio_decimator_if.slave  bus
);

  localparam int ACC_W = 16 + DECIM_LOG2;

  logic [DECIM_LOG2-1:0]   phase;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_sum;
  sample_t                 avg;
  logic                    wrap;
  logic                    wrap_d;

  assign wrap    = &phase;
  assign acc_sum = acc + ACC_W'(bus.sound_in);

  // The top 16 bits of the window sum are the floor-shifted average.
  always_ff @(posedge clk_49m or posedge reset) begin
    if (reset) begin
      phase           <= '0;
      acc             <= '0;
      avg             <= '0;
      wrap_d          <= 1'b0;
      bus.audio_valid <= 1'b0;
    end else begin
      phase           <= phase + DECIM_LOG2'(1);
      wrap_d          <= wrap;
      bus.audio_valid <= wrap_d;
      if (wrap) begin
        acc <= '0;
        avg <= acc_sum[ACC_W-1 -: 16];
      end else begin
        acc <= acc_sum;
      end
    end
  end

  tp84_dc_blocker #(
    .DC_SHIFT (DC_SHIFT)
  ) u_dc_blocker (
    .clk  (clk_49m),
    .rst  (reset),
    .ce   (wrap_d),
    .mute (bus.mute),
    .x    (avg),
    .y    (bus.audio_out)
  );

endmodule

// File: tb/tb_tp84_audio_decimator.sv
// Scoreboard bench for tp84_audio_decimator: window-average/filter model feeds a queue, a monitor checks strobes.
// Follows TP84_AUDIO_DCBLOCK_EN the same way as the design build.
module tb_tp84_audio_decimator;
  import tp84_audio_pkg::*;

  localparam int DECIM_LOG2 = 10;
  localparam int DC_SHIFT   = 8;
  localparam int W          = 1 << DECIM_LOG2;

  logic clk_49m = 1'b0;
  logic reset   = 1'b1;

  tp84_audio_decimator_if bus();

  tp84_audio_decimator #(
    .DECIM_LOG2 (DECIM_LOG2),
    .DC_SHIFT   (DC_SHIFT)
  ) dut (
    .clk_49m (clk_49m),
    .reset   (reset),
    .bus     (bus)
  );

  always #10 clk_49m = ~clk_49m;

  typedef struct {
    int          val;
    int unsigned at;
  } exp_t;

  exp_t        expq[$];
  exp_t        mon_e;
  int          checks = 0;
  int          fails  = 0;
  int          strobe_n = 0;
  bit          mon_en = 1'b0;
  sample_t     last_out = '0;

  // reference model state
  int unsigned edge_n = 0;
  longint      win_sum = 0;
  int          n_in_win = 0;
  int          pend_avg = 0;
  bit          have_pend = 1'b0;
  int          avg_prev_m = 0;
  int          y_prev_m = 0;

  function automatic longint floor_div(input longint a, input longint b);
    longint q;
    q = a / b;
    if ((a % b != 0) && ((a < 0) != (b < 0))) q = q - 1;
    return q;
  endfunction

  function automatic int clamp16(input int v);
    if (v > SAMPLE_MAX) return SAMPLE_MAX;
    if (v < SAMPLE_MIN) return SAMPLE_MIN;
    return v;
  endfunction

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d", name, got, want);
    end else begin
      $display("check %s: %0d ok", name, got);
    end
  endtask

  // Drive one sample for one clock; entered and left at a falling edge.
  task automatic drive(input int s, input bit m);
    int   y;
    exp_t e;
    bus.sound_in = 16'(s);
    bus.mute     = m;
    @(posedge clk_49m);
    edge_n++;
    if (have_pend) begin
`ifdef TP84_AUDIO_DCBLOCK_EN
      y = clamp16(pend_avg - avg_prev_m + y_prev_m - int'(floor_div(y_prev_m, 1 << DC_SHIFT)));
      avg_prev_m = pend_avg;
      y_prev_m   = y;
`else
      y = pend_avg;
`endif
      e.val = m ? 0 : y;
      e.at  = edge_n;
      expq.push_back(e);
      have_pend = 1'b0;
    end
    win_sum += longint'(s);
    n_in_win++;
    if (n_in_win == W) begin
      pend_avg  = int'(floor_div(win_sum, W));
      win_sum   = 0;
      n_in_win  = 0;
      have_pend = 1'b1;
    end
    @(negedge clk_49m);
  endtask

  task automatic model_reset();
    expq.delete();
    edge_n     = 0;
    win_sum    = 0;
    n_in_win   = 0;
    have_pend  = 1'b0;
    avg_prev_m = 0;
    y_prev_m   = 0;
  endtask

  // Monitor: every strobe pops the scoreboard; between strobes the output must hold.
  always @(negedge clk_49m) begin
    if (reset) begin
      last_out = '0;
    end else if (mon_en) begin
      if (bus.audio_valid === 1'b1) begin
        strobe_n++;
        checks++;
        if (expq.size() == 0) begin
          fails++;
          $display("FAIL unexpected_strobe: got strobe at edge %0d out=%0d, required no strobe",
                   edge_n, bus.audio_out);
        end else begin
          mon_e = expq.pop_front();
          if (bus.audio_out !== 16'(mon_e.val) || edge_n != mon_e.at) begin
            fails++;
            $display("FAIL strobe_%0d: got out=%0d at edge %0d, required out=%0d at edge %0d",
                     strobe_n, bus.audio_out, edge_n, mon_e.val, mon_e.at);
          end else begin
            $display("strobe %0d: out=%0d at edge %0d ok", strobe_n, bus.audio_out, edge_n);
          end
        end
      end else begin
        checks++;
        if (bus.audio_out !== last_out || bus.audio_valid !== 1'b0) begin
          fails++;
          $display("FAIL hold_edge_%0d: got out=%0d valid=%b, required out=%0d valid=0",
                   edge_n, bus.audio_out, bus.audio_valid, last_out);
        end
      end
      last_out = bus.audio_out;
    end
  end

  initial begin
    bus.sound_in = '0;
    bus.mute     = 1'b0;
    reset        = 1'b1;
    repeat (3) @(negedge clk_49m);
    chk("reset_audio_out", int'(bus.audio_out), 0);
    chk("reset_audio_valid", int'(bus.audio_valid), 0);
    reset  = 1'b0;
    mon_en = 1'b1;

    // constant input: plain level, or decaying DC-blocker response
    for (int w = 0; w < 3; w++)
      for (int i = 0; i < W; i++) drive(1000, 1'b0);

    // full-scale negative window then full-scale positive window
    for (int i = 0; i < W; i++) drive(-32768, 1'b0);
    for (int i = 0; i < W; i++) drive(32767, 1'b0);

    // +100/-101 alternation: window mean -0.5 floors to -1
    for (int i = 0; i < W; i++) drive((i % 2 == 0) ? 100 : -101, 1'b0);

    // mute for the last 4 clocks of a window and its output edge, then release
    for (int i = 0; i < W; i++) drive(5000, i >= W - 4);
    for (int i = 0; i < W; i++) drive(5000, i == 0);

    // random samples with occasional mute
    for (int w = 0; w < 6; w++)
      for (int i = 0; i < W; i++)
        drive(int'($urandom_range(0, 65535)) - 32768, $urandom_range(0, 15) == 0);

    // reset mid-window at counter 500 after a window of 20000
    for (int i = 0; i < W; i++) drive(20000, 1'b0);
    for (int i = 0; i < 500; i++) drive(20000, 1'b0);
    chk("pre_reset_out_nonzero", int'(bus.audio_out != 16'sd0), 1);
    reset = 1'b1;
    #1;
    chk("async_reset_audio_out", int'(bus.audio_out), 0);
    chk("async_reset_audio_valid", int'(bus.audio_valid), 0);
    model_reset();
    repeat (2) @(negedge clk_49m);
    reset = 1'b0;

    // post-reset windows must average post-reset samples only
    for (int i = 0; i < W; i++) drive(int'($urandom_range(0, 4000)) - 2000, 1'b0);
    for (int i = 0; i < W; i++) drive(7, 1'b0);
    for (int i = 0; i < 3; i++) drive(0, 1'b0);

    chk("scoreboard_drained", expq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/tp84_audio_decimator.md
TP84_AUDIO_DECIMATOR -- requirements
Module: tp84_audio_decimator

Interface
REQ-001 SHALL have parameter DECIM_LOG2, default 10, log2 of the decimation ratio (2^10 = 1024; 49.152 MHz / 1024 = 48 kHz).
REQ-002 SHALL have parameter DC_SHIFT, default 8, DC-blocker leak shift k, so the pole is 1-2^-k.
REQ-003 SHALL have port clk_49m, input, 1, sole clock (49.152 MHz).
REQ-004 SHALL have port reset, input, 1; one clock, reset asynchronous and active-high.
REQ-005 SHALL have port sound_in, input, signed 16, mixed game audio sampled on every clk_49m edge.
REQ-006 SHALL have port mute, input, 1, forces a silent output (driven from pause).
REQ-007 SHALL have port audio_out, output, signed 16, decimated and filtered sample.
REQ-008 SHALL have port audio_valid, output, 1, one-cycle strobe marking a new audio_out.

Function
REQ-009 SHALL keep a DECIM_LOG2-bit phase counter that increments every clock and wraps from 2^DECIM_LOG2-1 to 0.
REQ-010 SHALL accumulate sound_in into a signed accumulator of width 16+DECIM_LOG2 with no overflow.
REQ-011 On the wrap cycle (counter all ones), SHALL register avg = (acc + sound_in) >>> DECIM_LOG2 (arithmetic shift, truncation toward minus infinity) and SHALL load acc with 0 on the same edge.
REQ-012 SHALL apply the filter stage on the following edge: y = avg - avg_prev + y_prev - (y_prev >>> DC_SHIFT), computed at 18-bit signed width; avg_prev <= avg and y_prev <= saturated y.
REQ-013 SHALL saturate y to the range [-32768, +32767] before it drives audio_out and before it is stored as y_prev.
REQ-014 SHALL update audio_out and pulse audio_valid high for exactly one cycle, 2 clocks after the wrap cycle; the period between strobes SHALL be exactly 2^DECIM_LOG2 clocks.
REQ-015 While mute is high at the output edge, audio_out SHALL be 0 and audio_valid SHALL still pulse; filter state (avg_prev, y_prev) SHALL keep updating. When mute and a sample boundary coincide, mute SHALL win.
REQ-016 audio_out SHALL hold its value between strobes.

Reset
REQ-017 Reset SHALL clear the counter, acc, avg, avg_prev, y_prev and audio_out to 0, and audio_valid to 0, asynchronously.
REQ-018 Reset asserted mid-window SHALL discard the partial accumulation. After release, the first strobe SHALL occur 2^DECIM_LOG2+1 clocks after the first active edge.

Configuration
REQ-019 With macro TP84_AUDIO_DCBLOCK_EN defined, the filter of REQ-012 SHALL be present.
REQ-020 Without the macro, the filter stage SHALL be a plain register (y = avg); latency and strobe timing SHALL be identical, and DC_SHIFT SHALL be unused.

Structure
REQ-021 The shared package tp84_audio_pkg SHALL hold the sample typedef (signed 16), the constants SAMPLE_MAX = 32767 and SAMPLE_MIN = -32768, and the saturation function.
REQ-022 The filter SHALL be one sub-module, tp84_dc_blocker, with a clock-enable input driven by the delayed wrap strobe.

Verification
REQ-023 Macro off, sound_in = 1000 constant -> audio_out = 1000, audio_valid every 1024 clocks, first strobe 1025 clocks after reset release.
REQ-024 Macro on, sound_in = 1000 constant -> successive outputs 1000, 997 (1000 - 3), 994, and so on, decaying toward 0.
REQ-025 Macro on, sound_in = -32768 for one window then +32767 -> the second output saturates to +32767 with no wrap to negative.
REQ-026 Input alternating +100/-101 each clock, macro off -> avg = -1 (floor of -0.5), audio_out = -1.
REQ-027 mute raised 5 clocks before a strobe with sound_in = 5000 -> audio_out = 0 with the strobe still present. After mute is released, the next output continues from the unmuted filter state (macro on: 5000 - (y_prev >>> 8) path).
REQ-028 Reset pulsed at counter = 500 with sound_in = 20000 -> all outputs 0 immediately. The first post-reset output equals the average of post-reset samples only.
